// File: rtl/lfsr_key_scheduler_if.sv
// Key-source bus: control/seed inputs toward the scheduler, key stream and status back out.
interface lfsr_key_scheduler_if #(
   parameter int unsigned KEY_LEN   = 128,
   parameter int unsigned CNT_W     = 9,
   parameter int unsigned CNT_CNT_W = 16
);
   logic                 start;
   logic                 seed_load;
   logic [KEY_LEN-1:0]   seed;
   logic [CNT_W-1:0]     interval;
   logic [KEY_LEN-1:0]   key_out;
   logic                 key_valid;
   logic                 key_ready;
   logic                 lockup_err;
   logic [CNT_CNT_W-1:0] key_count;

   modport master (
      output start, seed_load, seed, interval, key_ready,
      input  key_out, key_valid, lockup_err, key_count
   );

   modport slave (
      input  start, seed_load, seed, interval, key_ready,
      output key_out, key_valid, lockup_err, key_count
   );
endinterface

// File: rtl/lfsr_key_scheduler.sv
// Fibonacci-LFSR key source: emits the LFSR state every N shifts over a valid/ready
// handshake, with runtime reseed, all-zero lockup trap and an accepted-key counter.
module lfsr_key_scheduler #(
   parameter int unsigned        KEY_LEN      = 128,
   parameter logic [KEY_LEN-1:0] TAPS         = KEY_LEN'(128'hA000_0014_0000_0000_0000_0000_0000_0000),
   parameter logic [KEY_LEN-1:0] DEFAULT_SEED = KEY_LEN'(128'd1234567),
   parameter int unsigned        CNT_W        = 9,
   parameter int unsigned        CNT_CNT_W    = 16
) (
   input  logic                  clock,
   input  logic                  preset_n,
   lfsr_key_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {RUN, HOLD, ERR} fsm_t;

   fsm_t                 fsm_q, fsm_d;
   logic [KEY_LEN-1:0]   lfsr_q, lfsr_d;
   logic [KEY_LEN-1:0]   key_q, key_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic [CNT_CNT_W-1:0] count_q, count_d;

   logic [CNT_W-1:0]     reload_c;
   logic [KEY_LEN-1:0]   shifted_c;

   // An interval of zero behaves as one shift per key
   assign reload_c  = (bus.interval == '0) ? CNT_W'(1) : bus.interval;
   assign shifted_c = {lfsr_q[KEY_LEN-2:0], ^(lfsr_q & TAPS)};

   // Next-state: seed_load overrides everything, including a same-cycle handshake
   always_comb begin
      fsm_d   = fsm_q;
      lfsr_d  = lfsr_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      err_d   = err_q;
      count_d = count_q;

      if (bus.seed_load) begin
         lfsr_d  = bus.seed;
         cnt_d   = reload_c;
         valid_d = 1'b0;
         if (bus.seed == '0) begin
            err_d = 1'b1;
            fsm_d = ERR;
         end else begin
            err_d = 1'b0;
            fsm_d = RUN;
         end
      end else begin
         case (fsm_q)
            RUN: begin
               if (bus.start) begin
                  lfsr_d = shifted_c;
                  if (cnt_q <= CNT_W'(1)) begin
                     key_d   = shifted_c;
                     valid_d = 1'b1;
                     fsm_d   = HOLD;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.key_ready) begin
                  valid_d = 1'b0;
                  count_d = count_q + CNT_CNT_W'(1);
                  cnt_d   = reload_c;
                  fsm_d   = RUN;
               end
            end
            ERR: begin
               valid_d = 1'b0;
            end
            default: begin
               fsm_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!preset_n) begin
         fsm_q   <= RUN;
         lfsr_q  <= DEFAULT_SEED;
         key_q   <= '0;
         cnt_q   <= reload_c;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         lfsr_q  <= lfsr_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   assign bus.key_out    = key_q;
   assign bus.key_valid  = valid_q;
   assign bus.lockup_err = err_q;
   assign bus.key_count  = count_q;

endmodule
